ex_stage: RTL

- Execute stage of the microcontroller pipeline. It sits directly downstream of the ID-to-EX pipeline register and consumes that register's clock-shifted outputs.
- Performs single-cycle ALU operations and an iterative multi-cycle multiply. Stalls upstream while a multiply is in progress.
- Registers results into EX-to-WB outputs and provides a one-deep result-forwarding path.

---
 rtl/ex_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative shift-add multiply with upstream stall,
// registered write-back outputs and a one-deep forwarding register.
module ex_stage #(
   parameter int DATA_W = 8,
   parameter int ADRS_W = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid_i,
   input  logic              wr_en_i,
   input  logic [3:0]        aluop_i,
   input  logic [1:0]        alusrc1_i,
   input  logic [1:0]        alusrc2_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [DATA_W-1:0] dat1_i,
   input  logic [DATA_W-1:0] dat2_i,
   input  logic [ADRS_W-1:0] dst_i,
   input  logic              dataoutv_i,
   output logic              stall_o,
   output logic              wb_en_o,
   output logic [ADRS_W-1:0] wb_adrs_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              dataoutv_o,
   output logic              carry_o,
   output logic              illegal_o
);

   localparam int SH_W = $clog2(DATA_W);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_PASS = 4'd8;

   typedef enum logic {IDLE, MUL} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [SH_W-1:0]     r_cnt;
   logic [DATA_W-1:0]   r_mcand;
   logic [DATA_W-1:0]   r_mplier;
   logic [DATA_W-1:0]   r_prod;
   logic [ADRS_W-1:0]   r_mDst;
   logic                r_mWrEn;
   logic                r_mDataOutV;
   logic [DATA_W-1:0]   r_fwd;
   logic                r_wbEn;
   logic [ADRS_W-1:0]   r_wbAdrs;
   logic [DATA_W-1:0]   r_wbData;
   logic                r_dataOutV;
   logic                r_carry;
   logic                r_illegal;

   logic [DATA_W-1:0]   w_op1;
   logic [DATA_W-1:0]   w_op2;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W-1:0]   w_res;
   logic [DATA_W-1:0]   w_step;
   logic                w_accept;
   logic                w_isMul;
   logic                w_illegal;
   logic                w_mulDone;

   assign w_accept  = in_valid_i && (r_state == IDLE);
   assign w_isMul   = (aluop_i == OP_MUL);
   assign w_illegal = (aluop_i > OP_PASS);
   assign w_mulDone = (r_state == MUL) && (r_cnt == SH_W'(DATA_W - 1));
   assign w_step    = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign w_sum     = {1'b0, w_op1} + {1'b0, w_op2};
   assign w_diff    = {1'b0, w_op1} - {1'b0, w_op2};

   assign stall_o    = (r_state == MUL);
   assign wb_en_o    = r_wbEn;
   assign wb_adrs_o  = r_wbAdrs;
   assign wb_data_o  = r_wbData;
   assign dataoutv_o = r_dataOutV;
   assign carry_o    = r_carry;
   assign illegal_o  = r_illegal;

   always_comb begin
      w_op1 = '0;
      w_op2 = '0;
      case (alusrc1_i)
         2'd0:    w_op1 = dat1_i;
         2'd1:    w_op1 = imm_i;
         2'd2:    w_op1 = r_fwd;
         default: w_op1 = '0;
      endcase
      case (alusrc2_i)
         2'd0:    w_op2 = dat2_i;
         2'd1:    w_op2 = imm_i;
         2'd2:    w_op2 = r_fwd;
         default: w_op2 = '0;
      endcase
   end

   always_comb begin
      w_res = '0;
      case (aluop_i)
         OP_ADD:  w_res = w_sum[DATA_W-1:0];
         OP_SUB:  w_res = w_diff[DATA_W-1:0];
         OP_AND:  w_res = w_op1 & w_op2;
         OP_OR:   w_res = w_op1 | w_op2;
         OP_XOR:  w_res = w_op1 ^ w_op2;
         OP_SHL:  w_res = w_op1 << w_op2[SH_W-1:0];
         OP_SHR:  w_res = w_op1 >> w_op2[SH_W-1:0];
         OP_PASS: w_res = w_op1;
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept && w_isMul) w_nextState = MUL;
         MUL:     if (w_mulDone) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Pulses default low each edge; data/address/carry/forward hold unless a result lands.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_prod      <= '0;
         r_mDst      <= '0;
         r_mWrEn     <= 1'b0;
         r_mDataOutV <= 1'b0;
         r_fwd       <= '0;
         r_wbEn      <= 1'b0;
         r_wbAdrs    <= '0;
         r_wbData    <= '0;
         r_dataOutV  <= 1'b0;
         r_carry     <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_wbEn     <= 1'b0;
         r_dataOutV <= 1'b0;
         r_illegal  <= 1'b0;
         if (r_state == MUL) begin
            r_prod   <= w_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mulDone) begin
               r_wbData   <= w_step;
               r_fwd      <= w_step;
               r_wbAdrs   <= r_mDst;
               r_wbEn     <= r_mWrEn;
               r_dataOutV <= r_mDataOutV;
            end
         end else if (w_accept) begin
            if (w_isMul) begin
               r_mcand     <= w_op1;
               r_mplier    <= w_op2;
               r_prod      <= '0;
               r_cnt       <= '0;
               r_mDst      <= dst_i;
               r_mWrEn     <= wr_en_i;
               r_mDataOutV <= dataoutv_i;
            end else if (w_illegal) begin
               r_wbData  <= '0;
               r_wbAdrs  <= dst_i;
               r_illegal <= 1'b1;
            end else begin
               r_wbData   <= w_res;
               r_fwd      <= w_res;
               r_wbAdrs   <= dst_i;
               r_wbEn     <= wr_en_i;
               r_dataOutV <= dataoutv_i;
               if (aluop_i == OP_ADD) r_carry <= w_sum[DATA_W];
               if (aluop_i == OP_SUB) r_carry <= w_diff[DATA_W];
            end
         end
      end
   end

endmodule
